wb_arbiter_2m: RTL and testbench
================================

// Module: wb_arbiter_2m
// PURPOSE
//  Two-master Wishbone B4 classic arbiter that shares one slave peripheral between requesters (e.g. core LSU and debug/DMA port).
//  Round-robin grant per bus cycle, owner held until it drops cyc. Slave watchdog aborts hung cycles with err to owner.
//  Sits between the masters and the peripheral's clk_i/rst_i/adr_i/dat_*/cyc/stb/we/sel/ack/err/rty interface.
// PARAMETERS
//  ADDR_WIDTH  `ADDR_WIDTH  address bus width
//  DATA_WIDTH  `DATA_WIDTH  data bus width
//  SEL_WIDTH   `SEL_WIDTH   byte-select width
//  TIMEOUT     16           max cycles stb may wait for ack/err/rty; legal range 1..255
// PORTS
//  clk_i            in   1           single clock, all logic rising-edge
//  rst_i            in   1           asynchronous reset, ACTIVE-LOW (0 = reset)
//  m{0,1}_cyc_i     in   1           master cycle request
//  m{0,1}_stb_i     in   1           master strobe
//  m{0,1}_we_i      in   1           master write enable
//  m{0,1}_lock_i    in   1           master lock (forwarded only)
//  m{0,1}_adr_i     in   ADDR_WIDTH  master address
//  m{0,1}_dat_i     in   DATA_WIDTH  master write data
//  m{0,1}_sel_i     in   SEL_WIDTH   master byte selects
//  m{0,1}_dat_o     out  DATA_WIDTH  read data (slave dat_i broadcast to both)
//  m{0,1}_ack_o     out  1           ack, owner only
//  m{0,1}_err_o     out  1           err, owner only (slave err OR watchdog abort)
//  m{0,1}_rty_o     out  1           rty, owner only
//  s_cyc_o/s_stb_o/s_we_o/s_lock_o   out 1   to slave, from owner
//  s_adr_o out ADDR_WIDTH; s_dat_o out DATA_WIDTH; s_sel_o out SEL_WIDTH   owner's bus
//  s_dat_i in DATA_WIDTH; s_ack_i/s_err_i/s_rty_i in 1   slave responses
//  gnt_o            out  2           one-hot current owner, 00 when idle (debug)
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, last_owner=1 (so m0 wins first tie), wdog=0; all s_* ctrl, ack/err/rty, gnt_o = 0.
//  FSM IDLE: if any cyc_i, latch owner -> BUSY next edge (1-cycle arbitration latency; slave cyc visible cycle after request).
//   Tie (both cyc_i): grant the master != last_owner. Single requester: grant it. Update last_owner on grant.
//  BUSY: s_* = owner's signals (mux by registered owner); other master sees ack/err/rty=0 and waits (cyc held).
//   Owner cyc_i=0 -> IDLE same edge, s_cyc_o drops combinationally; no idle bubble if other waits? No: always 1 IDLE cycle.
//   m_ack/err/rty = s_* & owner_stb; dat_o = s_dat_i to both masters.
//   wdog: +1 each cycle s_stb_o=1 and no ack/err/rty; cleared on any response or stb low. wdog==TIMEOUT-1 with no response -> ABORT.
//  ABORT: exactly one cycle: owner err_o=1, s_stb_o=s_cyc_o=0 (slave released), wdog=0 -> DRAIN.
//  DRAIN: s_cyc_o=0, no responses; wait owner cyc_i=0 -> IDLE.
//  Simultaneous slave response and timeout edge: response wins, wdog clears, stays BUSY.
//  Slave responses while IDLE/DRAIN are ignored (never forwarded). lock_i does not extend grant beyond cyc_i.
//  Reset asserted mid-cycle: immediate return to reset values; masters must restart.
//  Widths: wdog is 8 bits; no arithmetic elsewhere.
// STRUCTURE
//  Shared header wb_arb_defs.vh: state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_ABORT=2'd2, ST_DRAIN=2'd3; WDOG_W=8.
//  One sub-module: wb_watchdog (counter, clear/enable inputs, TIMEOUT param, expire pulse output).
//  Top: FSM + owner/last_owner regs + combinational bus muxes; ~200-300 lines.
// TESTING
//  1 m0 single read adr=0x10, slave ack after 2 cycles, s_dat_i=0xA5A5A5A5 -> m0_ack 1 cycle, m0_dat_o=0xA5A5A5A5, m1 ack=0.
//  2 m0,m1 cyc same cycle from reset -> gnt_o=01 first; after m0 drops cyc, 1 IDLE cycle, gnt_o=10; next tie -> 01.
//  3 m1 holds cyc across 4 pipelined-classic writes while m0 requests -> m0 stalled, all 4 writes reach slave from m1.
//  4 TIMEOUT=4, slave never acks -> after 4 stb cycles m0_err_o=1 one cycle, s_cyc_o=0; DRAIN until m0 cyc_i=0.
//  5 slave err and rty each once -> forwarded only to owner in same cycle; wdog cleared.
//  6 rst_i pulled low mid-BUSY -> all outputs 0 asynchronously, gnt_o=00; after release tie goes to m0.

Source files
------------

// File: rtl/wb_arbiter_2m_pkg.sv
// wb_arbiter_2m_pkg: shared state encodings, watchdog width and grant helper for the two-master arbiter
package wb_arbiter_2m_pkg;

    localparam int WDOG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Round-robin pick: on a tie the master that did not own last wins, otherwise the sole requester
    function automatic logic pick_owner(input logic cyc0, input logic cyc1, input logic last);
        return (cyc0 && cyc1) ? ~last : cyc1;
    endfunction

endpackage

// File: rtl/wb_arbiter_2m_watchdog.sv
// wb_arbiter_2m_watchdog: counts unanswered strobe cycles and pulses expire on the last allowed one
module wb_arbiter_2m_watchdog
    import wb_arbiter_2m_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt;

    // A response arriving on the final cycle suppresses the abort
    assign expire = en && !clr && (cnt == LAST);

    // Count waiting strobe cycles; any response, idle strobe or expiry restarts from zero
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            cnt <= '0;
        else if (clr || !en || expire)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone B4 classic arbiter with per-cycle round-robin grant and hung-slave abort
module wb_arbiter_2m
    import wb_arbiter_2m_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic                  m0_lock_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic                  m1_lock_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic                  s_lock_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [1:0]            gnt_o
);

    state_t state;
    logic   owner;
    logic   last_owner;
    logic   pick;
    logic   expire;
    logic   own_cyc;
    logic   own_stb;
    logic   busy;
    logic   abort;
    logic   fwd;
    logic   ack;
    logic   err;
    logic   rty;

    assign pick    = pick_owner(m0_cyc_i, m1_cyc_i, last_owner);
    assign busy    = (state == ST_BUSY);
    assign abort   = (state == ST_ABORT);
    assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner ? m1_stb_i : m0_stb_i;

    // Slave side follows the registered owner; control drops the moment the owner releases cyc
    assign s_cyc_o  = busy && own_cyc;
    assign s_stb_o  = s_cyc_o && own_stb;
    assign s_we_o   = s_cyc_o && (owner ? m1_we_i : m0_we_i);
    assign s_lock_o = s_cyc_o && (owner ? m1_lock_i : m0_lock_i);
    assign s_adr_o  = owner ? m1_adr_i : m0_adr_i;
    assign s_dat_o  = owner ? m1_dat_i : m0_dat_i;
    assign s_sel_o  = owner ? m1_sel_i : m0_sel_i;

    // Responses reach only the owner and only while its strobe is live; the abort cycle injects err
    assign fwd = s_stb_o;
    assign ack = fwd && s_ack_i;
    assign rty = fwd && s_rty_i;
    assign err = (fwd && s_err_i) || abort;

    assign m0_ack_o = ack && !owner;
    assign m0_err_o = err && !owner;
    assign m0_rty_o = rty && !owner;
    assign m1_ack_o = ack && owner;
    assign m1_err_o = err && owner;
    assign m1_rty_o = rty && owner;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    wb_arbiter_2m_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en     (s_stb_o),
        .clr    (s_ack_i || s_err_i || s_rty_i),
        .expire (expire)
    );

    // Grant a bus cycle, hold it until the owner drops cyc, and abort it if the slave hangs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            gnt_o      <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        state      <= ST_BUSY;
                        owner      <= pick;
                        last_owner <= pick;
                        gnt_o      <= pick ? 2'b10 : 2'b01;
                    end
                end
                ST_BUSY: begin
                    if (!own_cyc) begin
                        state <= ST_IDLE;
                        gnt_o <= 2'b00;
                    end else if (expire) begin
                        state <= ST_ABORT;
                    end
                end
                ST_ABORT: state <= ST_DRAIN;
                default: begin
                    if (!own_cyc) begin
                        state <= ST_IDLE;
                        gnt_o <= 2'b00;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed scoreboard bench for the two-master Wishbone arbiter
module tb_wb_arbiter_2m;

    localparam logic [2:0] K_ACK = 3'b100;
    localparam logic [2:0] K_ERR = 3'b010;
    localparam logic [2:0] K_RTY = 3'b001;

    typedef struct {
        logic [5:0]  vec;
        logic [31:0] dat;
        logic        scyc;
    } resp_t;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [1:0]  gnt;
    } slv_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic        m_lock[2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_lock_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i = 32'd0;
    logic        s_ack_i = 1'b0;
    logic        s_err_i = 1'b0;
    logic        s_rty_i = 1'b0;
    logic [1:0]  gnt_o;

    resp_t rq[$];
    slv_t  sq[$];
    int    checks = 0;
    int    failures = 0;
    int    slat = 1;
    int    smode = 0;
    int    scnt = 0;
    int    n;

    always #5 clk = ~clk;

    wb_arbiter_2m #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SEL_WIDTH  (4),
        .TIMEOUT    (4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .m0_cyc_i  (m_cyc[0]),
        .m0_stb_i  (m_stb[0]),
        .m0_we_i   (m_we[0]),
        .m0_lock_i (m_lock[0]),
        .m0_adr_i  (m_adr[0]),
        .m0_dat_i  (m_dat[0]),
        .m0_sel_i  (m_sel[0]),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m0_rty_o  (m0_rty_o),
        .m1_cyc_i  (m_cyc[1]),
        .m1_stb_i  (m_stb[1]),
        .m1_we_i   (m_we[1]),
        .m1_lock_i (m_lock[1]),
        .m1_adr_i  (m_adr[1]),
        .m1_dat_i  (m_dat[1]),
        .m1_sel_i  (m_sel[1]),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .m1_rty_o  (m1_rty_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_lock_o  (s_lock_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_rty_i   (s_rty_i),
        .gnt_o     (gnt_o)
    );

    // Slave model: answers after slat strobe cycles; smode 0 ack, 1 err, 2 rty, 3 never
    always @(posedge clk) begin
        s_ack_i <= 1'b0;
        s_err_i <= 1'b0;
        s_rty_i <= 1'b0;
        if (s_cyc_o && s_stb_o && !(s_ack_i || s_err_i || s_rty_i) && smode != 3) begin
            if (scnt + 1 >= slat) begin
                scnt    <= 0;
                s_ack_i <= (smode == 0);
                s_err_i <= (smode == 1);
                s_rty_i <= (smode == 2);
            end else begin
                scnt <= scnt + 1;
            end
        end else begin
            scnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic exp_resp(input int m, input logic [2:0] k, input logic [31:0] d, input logic scyc);
        resp_t r;
        r.vec  = (m == 1) ? {k, 3'b000} : {3'b000, k};
        r.dat  = d;
        r.scyc = scyc;
        rq.push_back(r);
    endtask

    task automatic exp_slv(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [1:0] gnt);
        slv_t s;
        s.adr = adr;
        s.we  = we;
        s.dat = dat;
        s.gnt = gnt;
        sq.push_back(s);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_i) begin : mon
                logic [5:0]  v;
                logic [31:0] d;
                resp_t       r;
                slv_t        s;
                v = {m1_ack_o, m1_err_o, m1_rty_o, m0_ack_o, m0_err_o, m0_rty_o};
                if (v != 6'd0) begin
                    if (rq.size() == 0) begin
                        chk("resp_unexpected", 128'(v), 128'(0));
                    end else begin
                        r = rq.pop_front();
                        d = r.vec[5] ? m1_dat_o : (r.vec[2] ? m0_dat_o : 32'd0);
                        chk("resp", 128'({v, s_cyc_o, d}),
                            128'({r.vec, r.scyc, (r.vec[5] | r.vec[2]) ? r.dat : 32'd0}));
                    end
                end
                if (s_cyc_o && s_stb_o && s_ack_i) begin
                    if (sq.size() == 0) begin
                        chk("slv_unexpected", 128'(sq.size()), 128'(1));
                    end else begin
                        s = sq.pop_front();
                        chk("slv_xfer", 128'({s_adr_o, s_we_o, s_dat_o, gnt_o}),
                            128'({s.adr, s.we, s.dat, s.gnt}));
                    end
                end
            end
        end
    endtask

    task automatic req(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_we[m]  = we;
        m_adr[m] = adr;
        m_dat[m] = dat;
        m_sel[m] = 4'hF;
    endtask

    task automatic rel(input int m);
        m_cyc[m]  = 1'b0;
        m_stb[m]  = 1'b0;
        m_we[m]   = 1'b0;
        m_lock[m] = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int m, output int cnt);
        logic seen;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 60) begin
            @(negedge clk);
            cnt++;
            seen = (m == 0) ? (m0_ack_o | m0_err_o | m0_rty_o) : (m1_ack_o | m1_err_o | m1_rty_o);
        end
        chk("resp_seen", 128'(seen), 128'(1));
        @(posedge clk);
        #1;
        m_stb[m] = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 128'({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_lock_o,
            m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 128'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; m_lock[i] = 1'b0;
            m_adr[i] = 32'd0; m_dat[i] = 32'd0; m_sel[i] = 4'd0;
        end
        fork
            monitor();
        join_none
        #1;
        do_reset();

        // Single m0 read, slave acks on the third strobe cycle
        smode = 0; slat = 2; s_dat_i = 32'hA5A5A5A5;
        exp_resp(0, K_ACK, 32'hA5A5A5A5, 1'b1);
        exp_slv(32'h10, 1'b0, 32'h0, 2'b01);
        req(0, 1'b0, 32'h10, 32'h0);
        wait_resp(0, n);
        chk("t1_latency", 128'(n), 128'(4));
        rel(0);
        idle(2);

        // Tie from reset, owner handover with one idle cycle, then tie goes back to m0
        do_reset();
        slat = 1; s_dat_i = 32'h11111111;
        exp_resp(0, K_ACK, 32'h11111111, 1'b1);
        exp_slv(32'h200, 1'b1, 32'hD0, 2'b01);
        exp_resp(1, K_ACK, 32'h11111111, 1'b1);
        exp_slv(32'h300, 1'b1, 32'hD1, 2'b10);
        req(0, 1'b1, 32'h200, 32'hD0);
        req(1, 1'b1, 32'h300, 32'hD1);
        @(negedge clk);
        chk("t2_arb_latency", 128'(gnt_o), 128'(2'b00));
        @(negedge clk);
        chk("t2_tie_gnt", 128'(gnt_o), 128'(2'b01));
        wait_resp(0, n);
        rel(0);
        @(negedge clk);
        chk("t2_release", 128'({gnt_o, s_cyc_o}), 128'({2'b01, 1'b0}));
        @(negedge clk);
        chk("t2_idle_bubble", 128'(gnt_o), 128'(2'b00));
        @(negedge clk);
        chk("t2_handover", 128'(gnt_o), 128'(2'b10));
        wait_resp(1, n);
        rel(1);
        idle(2);
        exp_resp(0, K_ACK, 32'h11111111, 1'b1);
        exp_slv(32'h204, 1'b0, 32'h0, 2'b01);
        exp_resp(1, K_ACK, 32'h11111111, 1'b1);
        exp_slv(32'h304, 1'b0, 32'h0, 2'b10);
        req(0, 1'b0, 32'h204, 32'h0);
        req(1, 1'b0, 32'h304, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t2_rr_tie_gnt", 128'(gnt_o), 128'(2'b01));
        wait_resp(0, n);
        rel(0);
        wait_resp(1, n);
        rel(1);
        idle(2);

        // m1 keeps its cycle over four writes while m0 waits
        s_dat_i = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            exp_resp(1, K_ACK, 32'h22222222, 1'b1);
            exp_slv(32'h400 + 32'(i * 4), 1'b1, 32'hC0DE0000 + 32'(i), 2'b10);
        end
        exp_resp(0, K_ACK, 32'h22222222, 1'b1);
        exp_slv(32'h20, 1'b0, 32'h0, 2'b01);
        req(1, 1'b1, 32'h400, 32'hC0DE0000);
        m_lock[1] = 1'b1;
        idle(1);
        req(0, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_resp(1, n);
            if (i < 3) req(1, 1'b1, 32'h400 + 32'((i + 1) * 4), 32'hC0DE0000 + 32'(i + 1));
        end
        @(negedge clk);
        chk("t3_lock_fwd", 128'({gnt_o, s_lock_o}), 128'({2'b10, 1'b1}));
        @(posedge clk);
        #1;
        rel(1);
        wait_resp(0, n);
        rel(0);
        idle(2);

        // Hung slave: abort after four strobe cycles, then drain until m0 drops cyc
        smode = 3;
        exp_resp(0, K_ERR, 32'h0, 1'b0);
        req(0, 1'b0, 32'h30, 32'h0);
        wait_resp(0, n);
        chk("t4_abort_latency", 128'(n), 128'(6));
        repeat (3) begin
            @(negedge clk);
            chk("t4_drain", 128'({gnt_o, s_cyc_o, s_stb_o, m0_err_o}), 128'({2'b01, 3'b000}));
        end
        rel(0);
        @(negedge clk);
        @(negedge clk);
        chk("t4_drain_exit", 128'(gnt_o), 128'(2'b00));
        idle(2);

        // Slave err then rty to m0 only; m1 then gets an ack landing on the timeout edge
        smode = 1; slat = 1; s_dat_i = 32'h33333333;
        exp_resp(0, K_ERR, 32'h0, 1'b1);
        exp_resp(0, K_RTY, 32'h0, 1'b1);
        exp_resp(1, K_ACK, 32'h33333333, 1'b1);
        exp_slv(32'h500, 1'b1, 32'hAB, 2'b10);
        req(0, 1'b0, 32'h50, 32'h0);
        idle(1);
        req(1, 1'b1, 32'h500, 32'hAB);
        wait_resp(0, n);
        smode = 2;
        m_stb[0] = 1'b1;
        wait_resp(0, n);
        smode = 0; slat = 3;
        rel(0);
        wait_resp(1, n);
        @(negedge clk);
        chk("t5_resp_wins", 128'({gnt_o, m1_err_o}), 128'({2'b10, 1'b0}));
        rel(1);
        idle(2);

        // Reset pulled mid-cycle clears outputs at once; afterwards a tie goes to m0
        smode = 3;
        req(0, 1'b0, 32'h60, 32'h0);
        idle(2);
        @(negedge clk);
        chk("t6_busy", 128'({gnt_o, s_cyc_o}), 128'({2'b01, 1'b1}));
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_async_reset", 128'({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_lock_o,
            m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 128'(0));
        rel(0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        smode = 0; slat = 1; s_dat_i = 32'h66666666;
        exp_resp(0, K_ACK, 32'h66666666, 1'b1);
        exp_slv(32'h600, 1'b1, 32'h6A, 2'b01);
        exp_resp(1, K_ACK, 32'h66666666, 1'b1);
        exp_slv(32'h700, 1'b1, 32'h7B, 2'b10);
        req(0, 1'b1, 32'h600, 32'h6A);
        req(1, 1'b1, 32'h700, 32'h7B);
        @(negedge clk);
        @(negedge clk);
        chk("t6_tie_after_reset", 128'(gnt_o), 128'(2'b01));
        wait_resp(0, n);
        rel(0);
        wait_resp(1, n);
        rel(1);
        idle(3);

        chk("resp_queue_empty", 128'(rq.size()), 128'(0));
        chk("slv_queue_empty", 128'(sq.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
